// File: rtl/tk1_led_pkg.sv
// tk1_led_pkg
//   Shared constants for the tk1 LED arbiter:
//   - register word addresses,
//   - LED_SRC_* encodings (the arbiter state doubles as the led_src value),
//   - the arbiter state enum,
//   - reset defaults of the programmable registers.
package tk1_led_pkg;

    localparam logic [7:0] ADDR_DUTY        = 8'h00;
    localparam logic [7:0] ADDR_BLINK_COLOR = 8'h01;
    localparam logic [7:0] ADDR_BLINK_HALF  = 8'h02;
    localparam logic [7:0] ADDR_BLINK_START = 8'h03;
    localparam logic [7:0] ADDR_STATUS      = 8'h04;

    localparam logic [1:0] LED_SRC_SW    = 2'd0;
    localparam logic [1:0] LED_SRC_BLINK = 2'd1;
    localparam logic [1:0] LED_SRC_TRAP  = 2'd2;

    // State values equal the led_src encodings so the state is visible
    // directly on led_src and in STATUS.
    typedef enum logic [1:0] {
        ST_SW    = LED_SRC_SW,
        ST_BLINK = LED_SRC_BLINK,
        ST_TRAP  = LED_SRC_TRAP
    } led_state_e;

    localparam logic [2:0] BLINK_COLOR_RST = 3'h0;
    localparam int         BLINK_HALF_RST  = 1;

endpackage

// File: rtl/tk1_led_arbiter_if.sv
// tk1_led_arbiter_if
//   Register access bus of the LED arbiter.
//   Handshake: cs is the request strobe, we selects write (1) or read (0).
//   ready mirrors cs, so every access completes in the cycle it is
//   presented; read_data is combinational and valid while cs is high.
//   Signals: cs, we, address[7:0], write_data[31:0], read_data[31:0], ready.
interface tk1_led_arbiter_if;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (output cs, we, address, write_data, input read_data, ready);
    modport slave  (input cs, we, address, write_data, output read_data, ready);
endinterface

// File: rtl/tk1_led_pwm.sv
// tk1_led_pwm
//   Free-running PWM counter with a shadowed duty value.
//   Ports:
//     clk, reset_n  clock, asynchronous active-low reset
//     duty          programmed duty (from the DUTY register)
//     en            PWM enable for the current cycle
module tk1_led_pwm #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PWM_W-1:0] duty,
    output logic             en
);

    logic [PWM_W-1:0] pwm_ctr_q, pwm_ctr_d;
    logic [PWM_W-1:0] active_duty_q, active_duty_d;

    // The active duty only changes when the counter wraps, so a period is
    // never cut short or stretched by a register write.
    always_comb begin
        pwm_ctr_d     = pwm_ctr_q + PWM_W'(1);
        active_duty_d = active_duty_q;
        if (pwm_ctr_q == '1) begin
            active_duty_d = duty;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_ctr_q     <= '0;
            active_duty_q <= '1;
        end else begin
            pwm_ctr_q     <= pwm_ctr_d;
            active_duty_q <= active_duty_d;
        end
    end

    // All-ones is a special case so that full duty is truly always on.
    assign en = (active_duty_q == '1) || (pwm_ctr_q < active_duty_q);

endmodule

// File: rtl/tk1_led_arbiter.sv
// tk1_led_arbiter
//   Arbitrates the RGB LED between CPU trap indication (highest), a
//   CPU-requested blink sequence and the static SW colour, and applies
//   global PWM dimming.
//   Ports:
//     clk, reset_n  clock, asynchronous active-low reset
//     cpu_trap      trap indication, enters the terminal TRAP state
//     sw_led        static colour {r,g,b}
//     bus           register access (slave side)
//     pwm_rgb       registered {r,g,b} PWM outputs
//     led_src       current source; equals the arbiter state register
module tk1_led_arbiter
    import tk1_led_pkg::*;
#(
    parameter int PWM_W      = 8,
    parameter int HALF_W     = 24,
    parameter int TRAP_CTR_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_trap,
    input  logic [2:0]          sw_led,
    tk1_led_arbiter_if.slave    bus,
    output logic [2:0]          pwm_rgb,
    output logic [1:0]          led_src
);

    led_state_e            state_q, state_d;
    logic [PWM_W-1:0]      duty_q, duty_d;
    logic [2:0]            blink_color_q, blink_color_d;
    logic [HALF_W-1:0]     blink_half_q, blink_half_d;
    logic [7:0]            blink_cnt_q, blink_cnt_d;
    logic [HALF_W-1:0]     half_ctr_q, half_ctr_d;
    logic                  phase_q, phase_d;
    logic [TRAP_CTR_W-1:0] trap_ctr_q, trap_ctr_d;
    logic                  trap_phase_q, trap_phase_d;
    logic [2:0]            pwm_rgb_q, pwm_rgb_d;

    logic        wr;
    logic        start_wr;
    logic [7:0]  start_n;
    logic [2:0]  colour;
    logic        en;
    logic [31:0] rdata;
    logic        unused_bits;

    assign wr       = bus.cs && bus.we;
    assign start_wr = wr && (bus.address == ADDR_BLINK_START);
    assign start_n  = bus.write_data[7:0];

    tk1_led_pwm #(.PWM_W(PWM_W)) u_pwm (
        .clk     (clk),
        .reset_n (reset_n),
        .duty    (duty_q),
        .en      (en)
    );

    // Register writes, arbiter next state and blink/trap counters.
    always_comb begin
        state_d       = state_q;
        duty_d        = duty_q;
        blink_color_d = blink_color_q;
        blink_half_d  = blink_half_q;
        blink_cnt_d   = blink_cnt_q;
        half_ctr_d    = half_ctr_q;
        phase_d       = phase_q;
        trap_ctr_d    = trap_ctr_q;
        trap_phase_d  = trap_phase_q;

        if (wr && bus.address == ADDR_DUTY) begin
            duty_d = bus.write_data[PWM_W-1:0];
        end
        if (wr && bus.address == ADDR_BLINK_COLOR) begin
            blink_color_d = bus.write_data[2:0];
        end
        // A zero half-period would never reload; store 1 instead.
        if (wr && bus.address == ADDR_BLINK_HALF) begin
            blink_half_d = (bus.write_data[HALF_W-1:0] == '0) ? HALF_W'(1)
                                                              : bus.write_data[HALF_W-1:0];
        end

        case (state_q)
            ST_SW: begin
                if (start_wr && start_n != 8'd0) begin
                    state_d     = ST_BLINK;
                    phase_d     = 1'b1;
                    half_ctr_d  = blink_half_q - HALF_W'(1);
                    blink_cnt_d = start_n;
                end
            end
            ST_BLINK: begin
                if (start_wr) begin
                    if (start_n != 8'd0) begin
                        phase_d     = 1'b1;
                        half_ctr_d  = blink_half_q - HALF_W'(1);
                        blink_cnt_d = start_n;
                    end else begin
                        state_d     = ST_SW;
                        phase_d     = 1'b0;
                        blink_cnt_d = 8'd0;
                    end
                end else if (half_ctr_q == '0) begin
                    half_ctr_d = blink_half_q - HALF_W'(1);
                    if (phase_q) begin
                        phase_d = 1'b0;
                    end else if (blink_cnt_q <= 8'd1) begin
                        // Last off period finished: hand back to SW.
                        state_d     = ST_SW;
                        blink_cnt_d = 8'd0;
                    end else begin
                        phase_d     = 1'b1;
                        blink_cnt_d = blink_cnt_q - 8'd1;
                    end
                end else begin
                    half_ctr_d = half_ctr_q - HALF_W'(1);
                end
            end
            ST_TRAP: begin
                trap_ctr_d = trap_ctr_q + TRAP_CTR_W'(1);
                if (trap_ctr_q == '1) begin
                    trap_phase_d = ~trap_phase_q;
                end
            end
            default: state_d = ST_SW;
        endcase

        // Trap overrides everything, including a same-cycle START write.
        if (cpu_trap && state_q != ST_TRAP) begin
            state_d     = ST_TRAP;
            phase_d     = 1'b0;
            half_ctr_d  = '0;
            blink_cnt_d = 8'd0;
        end
    end

    // Colour selection and PWM gating; trap ignores dimming.
    always_comb begin
        colour = 3'h0;
        case (state_q)
            ST_SW:    colour = sw_led;
            ST_BLINK: colour = phase_q ? blink_color_q : 3'h0;
            ST_TRAP:  colour = {trap_phase_q, 2'b00};
            default:  colour = 3'h0;
        endcase
        pwm_rgb_d = colour & {3{en || (state_q == ST_TRAP)}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_SW;
            duty_q        <= '1;
            blink_color_q <= BLINK_COLOR_RST;
            blink_half_q  <= HALF_W'(BLINK_HALF_RST);
            blink_cnt_q   <= 8'd0;
            half_ctr_q    <= '0;
            phase_q       <= 1'b0;
            trap_ctr_q    <= '0;
            trap_phase_q  <= 1'b0;
            pwm_rgb_q     <= 3'h0;
        end else begin
            state_q       <= state_d;
            duty_q        <= duty_d;
            blink_color_q <= blink_color_d;
            blink_half_q  <= blink_half_d;
            blink_cnt_q   <= blink_cnt_d;
            half_ctr_q    <= half_ctr_d;
            phase_q       <= phase_d;
            trap_ctr_q    <= trap_ctr_d;
            trap_phase_q  <= trap_phase_d;
            pwm_rgb_q     <= pwm_rgb_d;
        end
    end

    // Register read mux; unused bits read 0.
    always_comb begin
        rdata = 32'h0;
        if (bus.cs) begin
            case (bus.address)
                ADDR_DUTY:        rdata[PWM_W-1:0]  = duty_q;
                ADDR_BLINK_COLOR: rdata[2:0]        = blink_color_q;
                ADDR_BLINK_HALF:  rdata[HALF_W-1:0] = blink_half_q;
                ADDR_BLINK_START: rdata[7:0]        = blink_cnt_q;
                ADDR_STATUS:      rdata[1:0]        = state_q;
                default:          rdata             = 32'h0;
            endcase
        end
    end

    assign bus.read_data = rdata;
    assign bus.ready     = bus.cs;
    assign pwm_rgb       = pwm_rgb_q;
    assign led_src       = state_q;
    assign unused_bits   = &{1'b0, bus.write_data};

endmodule

// File: tb/tb_tk1_led_arbiter.sv
module tb_tk1_led_arbiter;
    import tk1_led_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_trap = 1'b0;
    logic [2:0] sw_led = 3'h0;
    logic [2:0] pwm_rgb;
    logic [1:0] led_src;

    int errors = 0;
    int checks = 0;

    tk1_led_arbiter_if bus_if();

    tk1_led_arbiter #(.PWM_W(8), .HALF_W(24), .TRAP_CTR_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_trap (cpu_trap),
        .sw_led   (sw_led),
        .bus      (bus_if),
        .pwm_rgb  (pwm_rgb),
        .led_src  (led_src)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus_if.cs = 1'b1;
        bus_if.we = 1'b1;
        bus_if.address = a;
        bus_if.write_data = d;
        tick(1);
        bus_if.cs = 1'b0;
        bus_if.we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic rdy);
        bus_if.cs = 1'b1;
        bus_if.we = 1'b0;
        bus_if.address = a;
        #1;
        d = bus_if.read_data;
        rdy = bus_if.ready;
        bus_if.cs = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Blink sequence expressed in time: j cycles after the start write,
    // phase is on during even half-periods, and the sequence lasts 2*n*h.
    function automatic logic [2:0] blink_colour(input int j, input int n, input int h,
                                                input logic [2:0] col, input logic [2:0] sw);
        if (j >= 2 * n * h) return sw;
        return (((j / h) % 2) == 0) ? col : 3'h0;
    endfunction

    function automatic logic [31:0] blink_remaining(input int j, input int n, input int h);
        if (j >= 2 * n * h) return 32'd0;
        return 32'(n - j / (2 * h));
    endfunction

    // Called right after the start write edge (j = 0).
    task automatic check_blink_run(input string name, input int n, input int h, input logic [2:0] col);
        int total;
        logic [2:0] exp_prev;
        logic [2:0] exp_col;
        logic [1:0] exp_src;
        logic [31:0] rd;
        logic rdy;
        total = 2 * n * h;
        exp_prev = 3'h0;
        for (int j = 0; j <= total + 2; j++) begin
            exp_col = blink_colour(j, n, h, col, sw_led);
            exp_src = (j < total) ? LED_SRC_BLINK : LED_SRC_SW;
            checks++;
            if (led_src !== exp_src) begin
                errors++;
                $display("FAIL %s_src j=%0d: got %0d expected %0d", name, j, led_src, exp_src);
            end
            if (j > 0) begin
                checks++;
                if (pwm_rgb !== exp_prev) begin
                    errors++;
                    $display("FAIL %s_pwm j=%0d: got %b expected %b", name, j, pwm_rgb, exp_prev);
                end
            end
            bus_read(ADDR_BLINK_START, rd, rdy);
            checks++;
            if (rd !== blink_remaining(j, n, h)) begin
                errors++;
                $display("FAIL %s_cnt j=%0d: got %0d expected %0d", name, j, rd, blink_remaining(j, n, h));
            end
            exp_prev = exp_col;
            tick(1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        logic rdy;
        reset_n = 1'b0;
        sw_led = 3'b110;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        checks++;
        if (pwm_rgb !== 3'b110) begin
            errors++;
            $display("FAIL reset_first_pwm: got %b expected 110", pwm_rgb);
        end
        tick(5);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pwm_rgb !== 3'b000 || led_src !== LED_SRC_SW) begin
            errors++;
            $display("FAIL reset_async: pwm=%b src=%0d expected 000/0", pwm_rgb, led_src);
        end
        tick(2);
        reset_n = 1'b1;
        bus_read(ADDR_DUTY, rd, rdy);
        checks++;
        if (rd !== 32'hff) begin
            errors++;
            $display("FAIL reset_duty: got %h expected ff", rd);
        end
        checks++;
        if (pwm_rgb !== 3'b000) begin
            errors++;
            $display("FAIL reset_pwm_held: got %b expected 000", pwm_rgb);
        end
        tick(1);
        checks++;
        if (pwm_rgb !== 3'b110) begin
            errors++;
            $display("FAIL reset_track_sw: got %b expected 110", pwm_rgb);
        end
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        logic rdy;
        logic [7:0] addr_tab[7];
        logic [31:0] exp_tab[7];
        bus_write(ADDR_DUTY, 32'h0000_1234);
        bus_write(ADDR_BLINK_COLOR, 32'hffff_ffff);
        bus_write(ADDR_BLINK_HALF, 32'h0);
        bus_write(8'h05, 32'hffff_ffff);
        bus_write(8'h80, 32'hffff_ffff);
        addr_tab = '{ADDR_DUTY, ADDR_BLINK_COLOR, ADDR_BLINK_HALF, ADDR_BLINK_START,
                     ADDR_STATUS, 8'h05, 8'h80};
        exp_tab  = '{32'h34, 32'h7, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            bus_read(addr_tab[i], rd, rdy);
            checks++;
            if (rd !== exp_tab[i]) begin
                errors++;
                $display("FAIL decode_read addr=%h: got %h expected %h", addr_tab[i], rd, exp_tab[i]);
            end
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("FAIL decode_ready addr=%h: got %b expected 1", addr_tab[i], rdy);
            end
        end
        #1;
        checks++;
        if (bus_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL decode_ready_idle: got %b expected 0", bus_if.ready);
        end
        bus_write(ADDR_BLINK_HALF, 32'h0100_0005);
        bus_read(ADDR_BLINK_HALF, rd, rdy);
        checks++;
        if (rd !== 32'h5) begin
            errors++;
            $display("FAIL decode_half_mask: got %h expected 5", rd);
        end
        bus_write(ADDR_DUTY, 32'hff);
        bus_write(ADDR_BLINK_COLOR, 32'h0);
    endtask

    task automatic test_dimming();
        logic [7:0] duty_tab[4];
        int on_cnt[3];
        int exp_on;
        sw_led = 3'($urandom_range(1, 7));
        duty_tab = '{8'h40, 8'h00, 8'($urandom_range(1, 254)), 8'hff};
        for (int d = 0; d < 4; d++) begin
            bus_write(ADDR_DUTY, {24'h0, duty_tab[d]});
            tick(520);
            for (int b = 0; b < 3; b++) on_cnt[b] = 0;
            for (int c = 0; c < 256; c++) begin
                for (int b = 0; b < 3; b++) on_cnt[b] += int'(pwm_rgb[b]);
                tick(1);
            end
            exp_on = (duty_tab[d] == 8'hff) ? 256 : int'(duty_tab[d]);
            for (int b = 0; b < 3; b++) begin
                checks++;
                if (on_cnt[b] !== (sw_led[b] ? exp_on : 0)) begin
                    errors++;
                    $display("FAIL dimming duty=%h bit=%0d: got %0d high cycles expected %0d",
                             duty_tab[d], b, on_cnt[b], sw_led[b] ? exp_on : 0);
                end
            end
        end
    endtask

    task automatic test_blink(input int n, input int h, input logic [2:0] col);
        sw_led = 3'($urandom_range(0, 7));
        bus_write(ADDR_BLINK_COLOR, {29'h0, col});
        bus_write(ADDR_BLINK_HALF, 32'(h));
        bus_write(ADDR_BLINK_START, 32'(n));
        check_blink_run("blink", n, h, col);
    endtask

    task automatic test_cancel();
        logic [31:0] rd;
        logic rdy;
        sw_led = 3'b101;
        bus_write(ADDR_BLINK_COLOR, 32'h2);
        bus_write(ADDR_BLINK_HALF, 32'd4);
        bus_write(ADDR_BLINK_START, 32'd3);
        tick(5);
        checks++;
        if (led_src !== LED_SRC_BLINK) begin
            errors++;
            $display("FAIL cancel_pre: got %0d expected 1", led_src);
        end
        bus_write(ADDR_BLINK_START, 32'd0);
        checks++;
        if (led_src !== LED_SRC_SW) begin
            errors++;
            $display("FAIL cancel_src: got %0d expected 0", led_src);
        end
        tick(1);
        checks++;
        if (pwm_rgb !== 3'b101) begin
            errors++;
            $display("FAIL cancel_pwm: got %b expected 101", pwm_rgb);
        end
        bus_read(ADDR_BLINK_START, rd, rdy);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL cancel_cnt: got %h expected 0", rd);
        end
    endtask

    task automatic test_restart();
        logic [2:0] col;
        col = 3'($urandom_range(1, 7));
        sw_led = 3'($urandom_range(0, 7));
        bus_write(ADDR_BLINK_COLOR, {29'h0, col});
        bus_write(ADDR_BLINK_HALF, 32'd4);
        bus_write(ADDR_BLINK_START, 32'd3);
        tick($urandom_range(5, 14));
        bus_write(ADDR_BLINK_START, 32'd5);
        check_blink_run("restart", 5, 4, col);
    endtask

    task automatic test_trap();
        logic [31:0] rd;
        logic rdy;
        logic [2:0] exp_pwm;
        bus_write(ADDR_DUTY, 32'h0);
        tick(520);
        bus_write(ADDR_BLINK_COLOR, 32'h3);
        bus_write(ADDR_BLINK_HALF, 32'd4);
        bus_write(ADDR_BLINK_START, 32'd3);
        tick(3);
        checks++;
        if (led_src !== LED_SRC_BLINK) begin
            errors++;
            $display("FAIL trap_pre: got %0d expected 1", led_src);
        end
        cpu_trap = 1'b1;
        bus_write(ADDR_BLINK_START, 32'd7);
        for (int j = 0; j < 70; j++) begin
            checks++;
            if (led_src !== LED_SRC_TRAP) begin
                errors++;
                $display("FAIL trap_src j=%0d: got %0d expected 2", j, led_src);
            end
            if (j > 0) begin
                exp_pwm = (((j - 1) / 16) % 2 == 1) ? 3'b100 : 3'b000;
                checks++;
                if (pwm_rgb !== exp_pwm) begin
                    errors++;
                    $display("FAIL trap_pwm j=%0d: got %b expected %b", j, pwm_rgb, exp_pwm);
                end
            end
            if (j == 10 || j == 30) begin
                bus_read(ADDR_BLINK_START, rd, rdy);
                checks++;
                if (rd !== 32'h0) begin
                    errors++;
                    $display("FAIL trap_cnt j=%0d: got %h expected 0", j, rd);
                end
            end
            if (j == 20) begin
                bus_if.cs = 1'b1;
                bus_if.we = 1'b1;
                bus_if.address = ADDR_BLINK_START;
                bus_if.write_data = 32'd2;
            end
            tick(1);
            bus_if.cs = 1'b0;
            bus_if.we = 1'b0;
        end
    endtask

    task automatic test_reset_mid_trap();
        logic [31:0] rd;
        logic rdy;
        logic [7:0] addr_tab[5];
        logic [31:0] exp_tab[5];
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pwm_rgb !== 3'b000 || led_src !== LED_SRC_SW) begin
            errors++;
            $display("FAIL trap_reset: pwm=%b src=%0d expected 000/0", pwm_rgb, led_src);
        end
        cpu_trap = 1'b0;
        sw_led = 3'b011;
        tick(2);
        reset_n = 1'b1;
        addr_tab = '{ADDR_DUTY, ADDR_BLINK_COLOR, ADDR_BLINK_HALF, ADDR_BLINK_START, ADDR_STATUS};
        exp_tab  = '{32'hff, 32'h0, 32'h1, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            bus_read(addr_tab[i], rd, rdy);
            checks++;
            if (rd !== exp_tab[i]) begin
                errors++;
                $display("FAIL trap_reset_defaults addr=%h: got %h expected %h", addr_tab[i], rd, exp_tab[i]);
            end
        end
        tick(1);
        checks++;
        if (pwm_rgb !== 3'b011) begin
            errors++;
            $display("FAIL trap_reset_sw: got %b expected 011", pwm_rgb);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus_if.cs = 1'b0;
        bus_if.we = 1'b0;
        bus_if.address = 8'h0;
        bus_if.write_data = 32'h0;
        test_reset();
        test_decode();
        test_dimming();
        test_blink(2, 4, 3'b010);
        for (int r = 0; r < 4; r++) begin
            test_blink($urandom_range(1, 4), $urandom_range(1, 6), 3'($urandom_range(1, 7)));
        end
        test_cancel();
        test_restart();
        test_trap();
        test_reset_mid_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
